// File: rtl/clk_cross_pkg.sv
// Shared definitions for the FIFO-to-BRAM mailbox bridge: the FSM state
// type, the BRAM word map and the helpers that build the two word formats.
package clk_cross_pkg;

  localparam int DATA_W  = 8;
  localparam int BRAM_DW = DATA_W + 1;
  localparam int BRAM_AW = 2;

  // BRAM map: word 0 is the control word, words 1..3 are rotating data slots.
  localparam logic [BRAM_AW-1:0] CTRL_ADDR  = 2'd0;
  localparam logic [BRAM_AW-1:0] SLOT_FIRST = 2'd1;
  localparam logic [BRAM_AW-1:0] SLOT_LAST  = 2'd3;

  // Control word fields: bit0 is the far-side request, bits[2:1] the last
  // slot written by this block. Data words carry a valid flag above the byte.
  localparam int REQ_BIT       = 0;
  localparam int CTRL_SLOT_LSB = 1;
  localparam int CTRL_SLOT_MSB = 2;
  localparam int VALID_BIT     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CTRL,
    ST_WAIT,
    ST_CHECK,
    ST_POP,
    ST_CAPTURE,
    ST_WR_DATA,
    ST_WR_CTRL
  } state_e;

  // Slot pointer sequence 1 -> 2 -> 3 -> 1; slot 0 is the control word.
  function automatic logic [BRAM_AW-1:0] next_slot(input logic [BRAM_AW-1:0] slot);
    return (slot == SLOT_LAST) ? SLOT_FIRST : slot + 2'd1;
  endfunction

  // Control word announcing the slot just written; REQ is written as 0,
  // which is how the far side's request gets consumed.
  function automatic logic [BRAM_DW-1:0] ctrl_word(input logic [BRAM_AW-1:0] slot);
    logic [BRAM_DW-1:0] w;
    w = '0;
    w[CTRL_SLOT_MSB:CTRL_SLOT_LSB] = slot;
    return w;
  endfunction

  // Data slot word: valid flag set above the payload byte.
  function automatic logic [BRAM_DW-1:0] data_word(input logic [DATA_W-1:0] b);
    logic [BRAM_DW-1:0] w;
    w = '0;
    w[VALID_BIT] = 1'b1;
    w[DATA_W-1:0] = b;
    return w;
  endfunction

endpackage

// File: rtl/clk_crossing_if.sv
// Bundle of the FIFO read side and BRAM port A seen by the bridge.
// master = the bridge; slave = the FIFO/BRAM side driving read data.
interface clk_crossing_if;
  import clk_cross_pkg::*;

  logic [DATA_W-1:0]  fifo_din;
  logic               fifo_ready;
  logic               rd_en;
  logic [BRAM_AW-1:0] bram_addra;
  logic [BRAM_DW-1:0] bram_dina;
  logic               bram_wea;
  logic [BRAM_DW-1:0] bram_douta;

  modport master (
    input  fifo_din,
    input  fifo_ready,
    input  bram_douta,
    output rd_en,
    output bram_addra,
    output bram_dina,
    output bram_wea
  );

  modport slave (
    output fifo_din,
    output fifo_ready,
    output bram_douta,
    input  rd_en,
    input  bram_addra,
    input  bram_dina,
    input  bram_wea
  );

endinterface

// File: rtl/clk_crossing_top.sv
// FIFO-to-BRAM mailbox bridge. Polls the REQ bit of the BRAM control word;
// when the far side asks for data and the FIFO is non-empty, pops one byte,
// writes it to the next rotating data slot and then rewrites the control
// word with that slot number (clearing REQ). All outputs are registered:
// each output register is loaded with the value belonging to the state the
// FSM is entering, so outputs are valid throughout that state's cycle.
module clk_crossing_top
  import clk_cross_pkg::*;
(
  input  logic         clk_25mhz,
  input  logic         rst,
  clk_crossing_if.master bus
);

  state_e             state_q, state_d;
  logic [BRAM_AW-1:0] slot_q, slot_d;
  logic [DATA_W-1:0]  byte_q, byte_d;
  logic [BRAM_AW-1:0] addra_q, addra_d;
  logic [BRAM_DW-1:0] dina_q, dina_d;
  logic               wea_q, wea_d;
  logic               rd_en_q, rd_en_d;

  // Only the REQ bit of the read-back control word matters here.
  logic unused_douta;
  assign unused_douta = &{1'b0, bus.bram_douta[BRAM_DW-1:1]};

  // Next-state logic; also captures the FIFO byte and advances the slot.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    byte_d  = byte_q;
    case (state_q)
      ST_IDLE:    if (bus.fifo_ready) state_d = ST_RD_CTRL;
      ST_RD_CTRL: state_d = ST_WAIT;
      ST_WAIT:    state_d = ST_CHECK;
      // Abort path: no request or FIFO drained -> back to IDLE, which re-polls.
      ST_CHECK:   state_d = (bus.bram_douta[REQ_BIT] && bus.fifo_ready) ? ST_POP : ST_IDLE;
      // From POP onward the transfer is committed regardless of fifo_ready.
      ST_POP:     state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        byte_d  = bus.fifo_din;
        state_d = ST_WR_DATA;
      end
      ST_WR_DATA: state_d = ST_WR_CTRL;
      ST_WR_CTRL: begin
        slot_d  = next_slot(slot_q);
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output values for the state being entered; addra holds when not accessing.
  always_comb begin
    addra_d = addra_q;
    dina_d  = '0;
    wea_d   = 1'b0;
    rd_en_d = 1'b0;
    case (state_d)
      ST_RD_CTRL: addra_d = CTRL_ADDR;
      ST_POP:     rd_en_d = 1'b1;
      ST_WR_DATA: begin
        // byte_d, not byte_q: the byte is captured on the same edge.
        addra_d = slot_q;
        dina_d  = data_word(byte_d);
        wea_d   = 1'b1;
      end
      ST_WR_CTRL: begin
        // slot_q still names the slot just written; it advances on exit.
        addra_d = CTRL_ADDR;
        dina_d  = ctrl_word(slot_q);
        wea_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // State, slot pointer, byte register and registered outputs.
  always_ff @(posedge clk_25mhz or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      slot_q  <= SLOT_FIRST;
      byte_q  <= '0;
      addra_q <= '0;
      dina_q  <= '0;
      wea_q   <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      byte_q  <= byte_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      wea_q   <= wea_d;
      rd_en_q <= rd_en_d;
    end
  end

  assign bus.bram_addra = addra_q;
  assign bus.bram_dina  = dina_q;
  assign bus.bram_wea   = wea_q;
  assign bus.rd_en      = rd_en_q;

endmodule

// File: tb/tb_clk_crossing_top.sv
// Bench for the mailbox bridge: behavioural BRAM and FIFO around the DUT,
// a negedge monitor logging pops and writes, and a transaction-level
// expectation (slot = 1 + transfers-since-reset mod 3, fixed latencies).
module tb_clk_crossing_top;
  import clk_cross_pkg::*;

  logic clk_25mhz = 1'b0;
  logic rst = 1'b0;
  clk_crossing_if bus();

  clk_crossing_top dut (
    .clk_25mhz (clk_25mhz),
    .rst       (rst),
    .bus       (bus)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk_25mhz) cyc <= cyc + 1;

  // BRAM: port A registered read and write; far side can set REQ.
  logic [8:0] mem [4];
  logic far_set = 1'b0;
  always @(posedge clk_25mhz) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      bus.bram_douta <= '0;
    end else begin
      bus.bram_douta <= mem[bus.bram_addra];
      if (bus.bram_wea) mem[bus.bram_addra] <= bus.bram_dina;
      else if (far_set) mem[0][0] <= 1'b1;
    end
  end

  // FIFO: standard read, data valid the cycle after rd_en.
  logic [7:0] fifo_mem [64];
  int fifo_wr = 0;
  int fifo_rd = 0;
  always @(posedge clk_25mhz) begin
    if (bus.rd_en && fifo_rd < fifo_wr) begin
      bus.fifo_din <= fifo_mem[fifo_rd % 64];
      fifo_rd <= fifo_rd + 1;
    end
  end

  // Event log.
  int         rd_cyc[$];
  int         wr_cyc[$];
  logic [1:0] wr_addr[$];
  logic [8:0] wr_data[$];
  always @(negedge clk_25mhz) begin
    if (rst) begin
      if (bus.rd_en) rd_cyc.push_back(cyc);
      if (bus.bram_wea) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(bus.bram_addra);
        wr_data.push_back(bus.bram_dina);
      end
    end
  end

  int rd_done = 0;
  int wr_done = 0;
  int xfers   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_25mhz);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[fifo_wr % 64] = b;
    fifo_wr++;
  endtask

  task automatic far_request();
    far_set = 1'b1;
    tick();
    far_set = 1'b0;
  endtask

  task automatic settle_idle();
    bus.fifo_ready = 1'b0;
    repeat (10) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_addra"}, 32'(bus.bram_addra), 0);
    check_eq({tag, "_dina"},  32'(bus.bram_dina),  0);
    check_eq({tag, "_wea"},   32'(bus.bram_wea),   0);
    check_eq({tag, "_rd_en"}, 32'(bus.rd_en),      0);
  endtask

  // Waits for one transfer's two writes and checks it against the model.
  task automatic check_transfer(input string tag, input logic [7:0] b, input int t0);
    int k;
    int exp_slot;
    k = 0;
    while (wr_cyc.size() < wr_done + 2 && k < 80) begin
      tick();
      k++;
    end
    exp_slot = 1 + (xfers % 3);
    if (wr_cyc.size() < wr_done + 2 || rd_cyc.size() < rd_done + 1) begin
      check_eq({tag, "_timeout_writes"}, 32'(wr_cyc.size()), 32'(wr_done + 2));
    end else begin
      check_eq({tag, "_pops"},      32'(rd_cyc.size()),       32'(rd_done + 1));
      check_eq({tag, "_data_addr"}, 32'(wr_addr[wr_done]),    32'(exp_slot));
      check_eq({tag, "_data_word"}, 32'(wr_data[wr_done]),    {23'd0, 1'b1, b});
      check_eq({tag, "_ctrl_addr"}, 32'(wr_addr[wr_done+1]),  0);
      check_eq({tag, "_ctrl_word"}, 32'(wr_data[wr_done+1]),  32'(exp_slot * 2));
      check_eq({tag, "_rd2data"},   32'(wr_cyc[wr_done] - rd_cyc[rd_done]), 2);
      check_eq({tag, "_data2ctrl"}, 32'(wr_cyc[wr_done+1] - wr_cyc[wr_done]), 1);
      if (t0 >= 0)
        check_eq({tag, "_rd_latency"}, 32'(rd_cyc[rd_done] - t0), 4);
    end
    rd_done = rd_cyc.size();
    wr_done = wr_cyc.size();
    xfers++;
  endtask

  initial begin
    logic [7:0] b;
    int t0;
    bus.fifo_ready = 1'b0;

    // Reset held
    repeat (3) tick();
    check_outputs_zero("reset_hold");

    // Release with FIFO empty
    rst = 1'b1;
    repeat (10) tick();
    check_outputs_zero("post_reset");
    check_eq("post_reset_pops",   32'(rd_cyc.size()), 0);
    check_eq("post_reset_writes", 32'(wr_cyc.size()), 0);

    // Polling with no request
    bus.fifo_ready = 1'b1;
    repeat (40) tick();
    check_eq("poll_pops",   32'(rd_cyc.size()), 0);
    check_eq("poll_writes", 32'(wr_cyc.size()), 0);

    // Single transfer from IDLE with exact latency
    settle_idle();
    push_byte(8'hAA);
    far_request();
    bus.fifo_ready = 1'b1;
    t0 = cyc;
    check_transfer("single", 8'hAA, t0);

    // Randomised back-to-back requests, covering slot wrap
    for (int i = 0; i < 7; i++) begin
      b = 8'($urandom);
      push_byte(b);
      repeat ($urandom_range(0, 6)) tick();
      check_eq("no_pop_without_req", 32'(rd_cyc.size()), 32'(rd_done));
      far_request();
      check_transfer("rand", b, -1);
    end

    // fifo_ready drops during WAIT: abort, no pop
    settle_idle();
    far_request();
    bus.fifo_ready = 1'b1;
    repeat (2) tick();
    bus.fifo_ready = 1'b0;
    repeat (12) tick();
    check_eq("abort_wait_pops",   32'(rd_cyc.size()), 32'(rd_done));
    check_eq("abort_wait_writes", 32'(wr_cyc.size()), 32'(wr_done));

    // fifo_ready drops during CAPTURE: transfer still completes
    b = 8'($urandom);
    push_byte(b);
    bus.fifo_ready = 1'b1;
    t0 = cyc;
    repeat (5) tick();
    bus.fifo_ready = 1'b0;
    check_transfer("abort_capture", b, t0);

    // Asynchronous reset during WR_DATA
    settle_idle();
    push_byte(8'($urandom));
    far_request();
    bus.fifo_ready = 1'b1;
    repeat (6) tick();
    check_eq("midrst_in_wr_data", 32'(bus.bram_wea), 1);
    check_eq("midrst_data_addr",  32'(bus.bram_addra), 32'(1 + (xfers % 3)));
    rst = 1'b0;
    #1;
    check_outputs_zero("midrst_async");
    bus.fifo_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rd_done = rd_cyc.size();
    wr_done = wr_cyc.size();
    xfers = 0;
    b = 8'($urandom);
    push_byte(b);
    far_request();
    bus.fifo_ready = 1'b1;
    t0 = cyc;
    check_transfer("after_rst", b, t0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
